// File: rtl/unibus_mem_slave.sv
// Unibus memory responder: DATI/DATO/DATOB over an MSYN/SSYN handshake with a
// programmable wait-state count. Build option ODD_ADDR_TRAP_EN: odd word cycles end in ERR.
module unibus_mem_slave #(
  parameter int          AW          = 12,
  parameter logic [15:0] BASE        = 16'o160000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msyn,
  input  logic [1:0]  c,
  input  logic [15:0] a,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        d_oe,
  output logic        ssyn,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int WORDS = 2 ** (AW - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   a_q;
  logic [1:0]      c_q;
  logic [15:0]     d_q;
  logic [15:0]     d_out_q;
  logic            ssyn_q;
  logic            d_oe_q;
`ifdef ODD_ADDR_TRAP_EN
  logic            err_q;
`endif

  logic [15:0]     mem [WORDS];

  logic            sel;
  logic [AW-1:0]   eff_a;
  logic [1:0]      eff_c;
  logic [15:0]     eff_d;
  logic [AW-2:0]   word;
  logic            is_wr;
  logic            is_byte;
  logic            trap;
  logic            fire;
  logic            wr_en;

  assign sel = msyn && (a[15:AW] == BASE[15:AW]);

  // The transfer happens on the ACK-entry edge. With zero wait states that edge
  // is the acceptance edge, so the live bus is used instead of the latched copy.
  always_comb begin
    eff_a   = a_q;
    eff_c   = c_q;
    eff_d   = d_q;
    if (state_q == S_IDLE) begin
      eff_a = a[AW-1:0];
      eff_c = c;
      eff_d = d_in;
    end
    word    = eff_a[AW-1:1];
    is_wr   = eff_c[1];
    is_byte = (eff_c == 2'b11);
`ifdef ODD_ADDR_TRAP_EN
    trap    = !is_byte && eff_a[0];
`else
    trap    = 1'b0;
`endif
    fire    = ((state_q == S_IDLE) && sel && (WAIT_CYCLES == 0)) ||
              ((state_q == S_WAIT) && msyn && (cnt_q == 4'd0));
    wr_en   = fire && !trap && is_wr && !reset;
  end

  // RAM has no reset: contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!is_byte) begin
        mem[word] <= eff_d;
      end else if (eff_a[0]) begin
        mem[word][15:8] <= eff_d[15:8];
      end else begin
        mem[word][7:0] <= eff_d[7:0];
      end
    end
  end

  // Handshake: the master holds msyn high while its request is valid; the slave
  // raises ssyn (or err) once, and holds it until msyn is seen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      c_q     <= 2'b00;
      d_q     <= 16'h0000;
      d_out_q <= 16'h0000;
      ssyn_q  <= 1'b0;
      d_oe_q  <= 1'b0;
`ifdef ODD_ADDR_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else if (fire) begin
      if (trap) begin
        state_q <= S_ERR;
`ifdef ODD_ADDR_TRAP_EN
        err_q   <= 1'b1;
`endif
      end else begin
        state_q <= S_ACK;
        ssyn_q  <= 1'b1;
        d_oe_q  <= !is_wr;
        if (!is_wr) begin
          d_out_q <= mem[word];
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel) begin
            a_q     <= a[AW-1:0];
            c_q     <= c;
            d_q     <= d_in;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!msyn) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          if (!msyn) begin
            state_q <= S_IDLE;
            ssyn_q  <= 1'b0;
            d_oe_q  <= 1'b0;
          end
        end
        S_ERR: begin
          if (!msyn) begin
            state_q <= S_IDLE;
`ifdef ODD_ADDR_TRAP_EN
            err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign d_out       = d_out_q;
  assign d_oe        = d_oe_q;
  assign ssyn        = ssyn_q;
  assign dbg_state_o = state_q;
`ifdef ODD_ADDR_TRAP_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_unibus_mem_slave.sv
// Directed bench for unibus_mem_slave: a transaction-level model predicts
// the handshake outputs, which are compared against the DUT on every falling edge.
module tb_unibus_mem_slave;

  localparam int W = 2;  // wait states; the driver timing assumes W >= 1

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msyn = 1'b0;
  logic [1:0]  c = 2'b00;
  logic [15:0] a = 16'h0000;
  logic [15:0] d_in = 16'h0000;
  logic [15:0] d_out;
  logic        d_oe;
  logic        ssyn;
  logic        err;
  logic [1:0]  dbg_state;

  localparam logic [1:0] DATI = 2'b00, RSVD = 2'b01, DATO = 2'b10, DATOB = 2'b11;

  always #5 clk = ~clk;

  unibus_mem_slave #(.AW(12), .BASE(16'o160000), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .msyn(msyn), .c(c), .a(a), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .ssyn(ssyn), .err(err), .dbg_state_o(dbg_state)
  );

  // Model state: memory image by word index, and what the outputs must read now.
  logic [15:0] mem_m [0:2047];
  logic [15:0] exp_q [$];
  logic        exp_ssyn = 1'b0;
  logic        exp_doe  = 1'b0;
  logic        exp_err  = 1'b0;
  logic [15:0] exp_dout = 16'h0000;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("ssyn",  16'(ssyn), 16'(exp_ssyn));
    chk("d_oe",  16'(d_oe), 16'(exp_doe));
    chk("err",   16'(err),  16'(exp_err));
    chk("d_out", d_out,     exp_dout);
  end

  // mode 0: normal, 1: drop msyn after one wait cycle, 2: reset while in ACK.
  task automatic xfer(input logic [1:0] cyc, input logic [15:0] addr,
                      input logic [15:0] data, input int mode);
    logic sel, rd, trap;
    int   w;
    sel  = (addr >= 16'o160000) && (addr <= 16'o167777);
    rd   = (cyc == DATI) || (cyc == RSVD);
    w    = int'(addr[11:1]);
    trap = 1'b0;
`ifdef ODD_ADDR_TRAP_EN
    trap = (cyc != DATOB) && addr[0];
`endif
    @(negedge clk);
    a = addr; c = cyc; d_in = data; msyn = 1'b1;
    if (!sel) begin
      repeat (20) @(posedge clk);
      @(negedge clk); msyn = 1'b0;
      @(negedge clk);
      return;
    end
    if (rd && !trap) exp_q.push_back(mem_m[w]);
    @(posedge clk);                 // request accepted
    @(negedge clk);
    a = ~addr; c = ~cyc; d_in = ~data;  // must be ignored from here on
    @(posedge clk);                 // first wait cycle
    if (mode == 1) begin
      @(negedge clk); msyn = 1'b0;
      repeat (3) @(posedge clk);
      if (rd) void'(exp_q.pop_back());
      @(negedge clk);
      return;
    end
    repeat (W - 1) @(posedge clk);
    @(posedge clk);                 // acknowledge edge: accept + W + 1
    if (trap) begin
      exp_err = 1'b1;
    end else begin
      exp_ssyn = 1'b1;
      if (rd) begin
        exp_doe  = 1'b1;
        exp_dout = exp_q.pop_front();
      end else if (cyc == DATOB) begin
        if (addr[0]) mem_m[w][15:8] = data[15:8];
        else         mem_m[w][7:0]  = data[7:0];
      end else begin
        mem_m[w] = data;
      end
    end
    if (mode == 2) begin
      #2 reset = 1'b1;
      exp_ssyn = 1'b0; exp_doe = 1'b0; exp_err = 1'b0; exp_dout = 16'h0000;
      #1;
      chk("rst_ack_ssyn", 16'(ssyn), 16'h0000);
      chk("rst_ack_doe",  16'(d_oe), 16'h0000);
      @(negedge clk); msyn = 1'b0; reset = 1'b0;
      @(negedge clk);
      return;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); msyn = 1'b0;
    @(posedge clk);                 // release edge
    exp_ssyn = 1'b0; exp_doe = 1'b0; exp_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout",  d_out, 16'h0000);
    chk("rst_state", 16'(dbg_state), 16'h0000);
    reset = 1'b0;

    xfer(DATO, 16'o160010, 16'h1234, 0);
    xfer(DATI, 16'o160010, 16'h0000, 0);
    chk("lit_rd_160010", d_out, 16'h1234);

    xfer(DATO,  16'o160020, 16'hABCD, 0);
    xfer(DATOB, 16'o160021, 16'h5500, 0);
    xfer(DATOB, 16'o160020, 16'h0077, 0);
    xfer(DATI,  16'o160020, 16'h0000, 0);
    chk("lit_bytes_160020", d_out, 16'h5577);

    xfer(DATI, 16'o157776, 16'h0000, 0);
    chk("lit_unsel_hold", d_out, 16'h5577);

    xfer(DATO, 16'o160030, 16'h0000, 0);
    xfer(DATO, 16'o160030, 16'h1111, 1);
    xfer(DATI, 16'o160030, 16'h0000, 0);
    chk("lit_abort_160030", d_out, 16'h0000);

    xfer(RSVD, 16'o160010, 16'h0000, 0);
    chk("lit_rsvd_read", d_out, 16'h1234);

    xfer(DATI, 16'o160010, 16'h0000, 2);
    chk("lit_after_rst", d_out, 16'h0000);
    xfer(DATI, 16'o160010, 16'h0000, 0);
    chk("lit_persist_160010", d_out, 16'h1234);

    xfer(DATO, 16'o160012, 16'h2222, 0);
    xfer(DATO, 16'o160013, 16'hFFFF, 0);
    xfer(DATI, 16'o160012, 16'h0000, 0);
`ifdef ODD_ADDR_TRAP_EN
    chk("lit_odd_dato", d_out, 16'h2222);
`else
    chk("lit_odd_dato", d_out, 16'hFFFF);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
